paralelo_serial: RTL and testbench

- Serializer stage downstream of the clock generator. Runs on clk8f and consumes one 8-bit word per clkf period, which is 8 clk8f cycles.
- Emits the word MSB-first on a 1-bit lane.
- Sends the comma symbol COM on the lane in two cases:
  - during a post-reset preamble;
  - whenever the upstream word is not valid.
- Provides the serial lane plus framing flags for the downstream receiver/deserializer.

---
 rtl/paralelo_serial_pkg.sv | 13 +
 rtl/paralelo_serial_shift_reg_piso.sv | 27 ++
 rtl/paralelo_serial.sv | 92 +++++++++
 tb/tb_paralelo_serial.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the serializer, deserializer and comma detector:
// word width, comma symbol and link state encoding.
package paralelo_serial_pkg;

    localparam int           WORD_W     = 8;
    localparam logic [7:0]   COM_SYMBOL = 8'hBC;

    typedef enum logic {
        ST_PREAMBLE = 1'b0,
        ST_DATA     = 1'b1
    } state_t;

endpackage

// File: rtl/paralelo_serial_shift_reg_piso.sv
// Parallel-load / shift-left register; the MSB is the serial output.
module shift_reg_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_shreg[W-1];

endmodule

// File: rtl/paralelo_serial.sv
// 8:1 serializer on clk8f: one word per 8 cycles, MSB first, with a post-reset
// comma preamble and comma insertion for invalid upstream words.
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter int         WIDTH          = WORD_W,
    parameter logic [7:0] COM            = COM_SYMBOL,
    parameter int         PREAMBLE_WORDS = 4
) (
    input  logic             clk8f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             data_out,
    output logic             word_start,
    output logic             idle_out,
    output logic             synced
);

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_WORDS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_pre_cnt;
    logic             r_word_start;
    logic             r_idle;
    logic             w_capture;
    logic             w_sel_com;
    logic [WIDTH-1:0] w_sel;

    assign w_capture = (r_bit_idx == 3'd7);

    // State register
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_PREAMBLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: the capture sending the last preamble COM moves to DATA
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_PREAMBLE && w_capture && r_pre_cnt == PRE_LAST) begin
            w_state_next = ST_DATA;
        end
    end

    // Word selection
    always_comb begin
        w_sel_com = (r_state == ST_PREAMBLE) || !valid_in;
        w_sel     = w_sel_com ? COM : data_in;
    end

    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_bit_idx    <= 3'd7;
            r_pre_cnt    <= 4'd0;
            r_word_start <= 1'b0;
            r_idle       <= 1'b0;
        end else if (w_capture) begin
            r_bit_idx    <= 3'd0;
            r_word_start <= 1'b1;
            r_idle       <= w_sel_com;
            if (r_state == ST_PREAMBLE) begin
                r_pre_cnt <= r_pre_cnt + 4'd1;
            end
        end else begin
            r_bit_idx    <= r_bit_idx + 3'd1;
            r_word_start <= 1'b0;
        end
    end

    // Shift register MSB is the lane, so data_out is a direct register output
    shift_reg_piso #(
        .W (WIDTH)
    ) u_piso (
        .clk     (clk8f),
        .rst_n   (reset),
        .i_load  (w_capture),
        .i_shift (!w_capture),
        .i_data  (w_sel),
        .o_msb   (data_out)
    );

    assign word_start = r_word_start;
    assign idle_out   = r_idle;
    assign synced     = (r_state == ST_DATA);

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: collects each 8-bit word off the lane and
// compares lane bits and framing flags against hand-computed values.
module tb_paralelo_serial;

    logic       clk8f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out, word_start, idle_out, synced;

    int vectors = 0;
    int miscompares = 0;

    paralelo_serial #(.WIDTH(8), .COM(8'hBC), .PREAMBLE_WORDS(4)) dut (
        .clk8f      (clk8f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .word_start (word_start),
        .idle_out   (idle_out),
        .synced     (synced)
    );

    always #5 clk8f = ~clk8f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // Samples the 8 bit periods of one word on negedges; first sample lands in bit 7.
    task automatic collect_word(output logic [7:0] bits, output logic [7:0] ws,
                                output logic [7:0] idl, output logic [7:0] syn);
        bits = '0; ws = '0; idl = '0; syn = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk8f);
            bits = {bits[6:0], data_out};
            ws   = {ws[6:0], word_start};
            idl  = {idl[6:0], idle_out};
            syn  = {syn[6:0], synced};
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk8f);
        vectors++; if (data_out !== 1'b0) begin miscompares++; $display("FAIL reset_data_out got %b want 0", data_out); end
        vectors++; if (word_start !== 1'b0) begin miscompares++; $display("FAIL reset_word_start got %b want 0", word_start); end
        vectors++; if (idle_out !== 1'b0) begin miscompares++; $display("FAIL reset_idle_out got %b want 0", idle_out); end
        vectors++; if (synced !== 1'b0) begin miscompares++; $display("FAIL reset_synced got %b want 0", synced); end
        $display("reset: outputs %b%b%b%b", data_out, word_start, idle_out, synced);
    endtask

    // Releases reset on a negedge with 8'hFF valid; checks 4 COM words then 8'hFF.
    task automatic test_preamble();
        logic [7:0] b, w, i, s;
        data_in = 8'hFF; valid_in = 1'b1;
        @(negedge clk8f);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            collect_word(b, w, i, s);
            $display("preamble word %0d: bits=%h ws=%h idle=%h synced=%h", k, b, w, i, s);
            vectors++; if (b !== 8'hBC) begin miscompares++; $display("FAIL pre%0d_bits got %h want bc", k, b); end
            vectors++; if (w !== 8'h80) begin miscompares++; $display("FAIL pre%0d_word_start got %h want 80", k, w); end
            vectors++; if (i !== 8'hFF) begin miscompares++; $display("FAIL pre%0d_idle got %h want ff", k, i); end
            vectors++;
            if (s !== ((k == 4) ? 8'hFF : 8'h00)) begin
                miscompares++; $display("FAIL pre%0d_synced got %h want %h", k, s, (k == 4) ? 8'hFF : 8'h00);
            end
        end
        collect_word(b, w, i, s);
        $display("first data word: bits=%h ws=%h idle=%h synced=%h", b, w, i, s);
        vectors++; if (b !== 8'hFF) begin miscompares++; $display("FAIL first_data_bits got %h want ff", b); end
        vectors++; if (i !== 8'h00) begin miscompares++; $display("FAIL first_data_idle got %h want 00", i); end
        vectors++; if (s !== 8'hFF) begin miscompares++; $display("FAIL first_data_synced got %h want ff", s); end
    endtask

    task automatic test_data_word();
        logic [7:0] b, w, i, s;
        data_in = 8'hA5; valid_in = 1'b1;
        collect_word(b, w, i, s);
        $display("data A5: bits=%h ws=%h idle=%h", b, w, i);
        vectors++; if (b !== 8'hA5) begin miscompares++; $display("FAIL data_a5_bits got %h want a5", b); end
        vectors++; if (w !== 8'h80) begin miscompares++; $display("FAIL data_a5_word_start got %h want 80", w); end
        vectors++; if (i !== 8'h00) begin miscompares++; $display("FAIL data_a5_idle got %h want 00", i); end
    endtask

    task automatic test_idle_insert();
        logic [7:0] b, w, i, s;
        data_in = 8'h3C; valid_in = 1'b0;
        collect_word(b, w, i, s);
        $display("idle word: bits=%h idle=%h", b, i);
        vectors++; if (b !== 8'hBC) begin miscompares++; $display("FAIL idle_bits got %h want bc", b); end
        vectors++; if (i !== 8'hFF) begin miscompares++; $display("FAIL idle_flag got %h want ff", i); end
        data_in = 8'h5A; valid_in = 1'b1;
        collect_word(b, w, i, s);
        $display("after idle 5A: bits=%h idle=%h", b, i);
        vectors++; if (b !== 8'h5A) begin miscompares++; $display("FAIL after_idle_bits got %h want 5a", b); end
        vectors++; if (i !== 8'h00) begin miscompares++; $display("FAIL after_idle_flag got %h want 00", i); end
    endtask

    task automatic test_midword_change();
        logic [7:0] b, w, i, s;
        data_in = 8'h0F; valid_in = 1'b1;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk8f);
            b = {b[6:0], data_out};
            // k==3 is the bit period with bit_idx==3
            if (k == 3) begin
                data_in = 8'hF0; valid_in = 1'b0;
            end
        end
        $display("midword change: in-flight bits=%h", b);
        vectors++; if (b !== 8'h0F) begin miscompares++; $display("FAIL midword_inflight got %h want 0f", b); end
        collect_word(b, w, i, s);
        $display("midword change: next bits=%h idle=%h", b, i);
        vectors++; if (b !== 8'hBC) begin miscompares++; $display("FAIL midword_next_bits got %h want bc", b); end
        vectors++; if (i !== 8'hFF) begin miscompares++; $display("FAIL midword_next_idle got %h want ff", i); end
    endtask

    task automatic test_com_as_data();
        logic [7:0] b, w, i, s;
        data_in = 8'hBC; valid_in = 1'b1;
        collect_word(b, w, i, s);
        $display("data BC: bits=%h idle=%h", b, i);
        vectors++; if (b !== 8'hBC) begin miscompares++; $display("FAIL com_data_bits got %h want bc", b); end
        vectors++; if (i !== 8'h00) begin miscompares++; $display("FAIL com_data_idle got %h want 00", i); end
    endtask

    task automatic test_midword_reset();
        logic [7:0] b, w, i, s;
        data_in = 8'hFF; valid_in = 1'b1;
        repeat (5) @(negedge clk8f);
        // Now in bit_idx==4 of an FF word; lane is 1, idle 0, synced 1.
        #2 reset = 1'b0;
        #1;
        $display("midword reset: outputs %b%b%b%b", data_out, word_start, idle_out, synced);
        vectors++; if (data_out !== 1'b0) begin miscompares++; $display("FAIL async_rst_data_out got %b want 0", data_out); end
        vectors++; if (word_start !== 1'b0) begin miscompares++; $display("FAIL async_rst_word_start got %b want 0", word_start); end
        vectors++; if (idle_out !== 1'b0) begin miscompares++; $display("FAIL async_rst_idle got %b want 0", idle_out); end
        vectors++; if (synced !== 1'b0) begin miscompares++; $display("FAIL async_rst_synced got %b want 0", synced); end
        @(negedge clk8f);
        data_in = 8'h77; valid_in = 1'b1;
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            collect_word(b, w, i, s);
            $display("re-preamble word %0d: bits=%h idle=%h synced=%h", k, b, i, s);
            vectors++; if (b !== 8'hBC) begin miscompares++; $display("FAIL repre%0d_bits got %h want bc", k, b); end
            vectors++; if (i !== 8'hFF) begin miscompares++; $display("FAIL repre%0d_idle got %h want ff", k, i); end
        end
        collect_word(b, w, i, s);
        $display("after re-preamble: bits=%h idle=%h", b, i);
        vectors++; if (b !== 8'h77) begin miscompares++; $display("FAIL repre_data_bits got %h want 77", b); end
        vectors++; if (i !== 8'h00) begin miscompares++; $display("FAIL repre_data_idle got %h want 00", i); end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_data_word();
        test_idle_insert();
        test_midword_change();
        test_com_as_data();
        test_midword_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
